// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with single-cycle logic/arith/shift ops and
// an N-cycle shift-add multiplier. Results, Zero and Overflow update together
// with a one-cycle Done pulse; Busy marks the multiply execution phase.
module multicycle_alu #(
    parameter int unsigned N = 64
) (
    input  logic         CLK,
    input  logic         resetl,
    input  logic         Start,
    input  logic [3:0]   ALUCtrl,
    input  logic [N-1:0] BusA,
    input  logic [N-1:0] BusB,
    output logic [N-1:0] BusW,
    output logic         Zero,
    output logic         Overflow,
    output logic         Busy,
    output logic         Done
);

    localparam int unsigned SW = $clog2(N);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [SW-1:0]  cnt;
    logic [N-1:0]   op_a;      // multiplicand, shifted left each EXEC cycle
    logic [N-1:0]   op_b;      // multiplier, shifted right each EXEC cycle
    logic [3:0]     op_ctrl;
    logic [N-1:0]   acc;

    logic           accept;
    logic           mul_step;
    logic           mul_last;
    logic [N-1:0]   acc_next;

    logic [N-1:0]   sum;
    logic [N-1:0]   diff;
    logic [N-1:0]   alu_res;
    logic           alu_ovf;

    assign accept   = (state != EXEC) && Start;
    assign mul_step = (state == EXEC) && (op_ctrl == OP_MUL);
    assign mul_last = mul_step && (cnt == SW'(N - 1));
    assign acc_next = op_b[0] ? (acc + op_a) : acc;

    assign Busy = (state == EXEC);
    assign Done = (state == DONE);

    // State register
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: Start is only honoured outside EXEC
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_next = (ALUCtrl == OP_MUL) ? EXEC : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                if (cnt == SW'(N - 1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle result computed straight from the bus so it lands on the
    // accepting edge; the latched copies only feed the multiplier.
    always_comb begin
        sum     = BusA + BusB;
        diff    = BusA - BusB;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUCtrl)
            OP_AND:  alu_res = BusA & BusB;
            OP_OR:   alu_res = BusA | BusB;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (BusA[N-1] == BusB[N-1]) && (sum[N-1] != BusA[N-1]);
            end
            OP_LSL:  alu_res = BusA << BusB[SW-1:0];
            OP_LSR:  alu_res = BusA >> BusB[SW-1:0];
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (BusA[N-1] != BusB[N-1]) && (diff[N-1] != BusA[N-1]);
            end
            OP_PASS: alu_res = BusB;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Operand latch, shift-add multiplier and result registers
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            op_a     <= '0;
            op_b     <= '0;
            op_ctrl  <= '0;
            acc      <= '0;
            cnt      <= '0;
            BusW     <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
        end else if (accept) begin
            op_a    <= BusA;
            op_b    <= BusB;
            op_ctrl <= ALUCtrl;
            acc     <= '0;
            cnt     <= '0;
            if (ALUCtrl != OP_MUL) begin
                BusW     <= alu_res;
                Zero     <= (alu_res == '0);
                Overflow <= alu_ovf;
            end
        end else if (mul_step) begin
            acc  <= acc_next;
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
            cnt  <= cnt + 1'b1;
            if (mul_last) begin
                BusW     <= acc_next;
                Zero     <= (acc_next == '0);
                Overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu (N=64): a cycle-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_multicycle_alu;

    localparam int unsigned N  = 64;
    localparam int unsigned SW = $clog2(N);

    logic         CLK = 1'b0;
    logic         resetl = 1'b0;
    logic         Start = 1'b0;
    logic [3:0]   ALUCtrl = 4'b0000;
    logic [N-1:0] BusA = '0;
    logic [N-1:0] BusB = '0;
    logic [N-1:0] BusW;
    logic         Zero;
    logic         Overflow;
    logic         Busy;
    logic         Done;

    int n_vec = 0;
    int n_err = 0;

    multicycle_alu #(.N(N)) dut (
        .CLK      (CLK),
        .resetl   (resetl),
        .Start    (Start),
        .ALUCtrl  (ALUCtrl),
        .BusA     (BusA),
        .BusB     (BusB),
        .BusW     (BusW),
        .Zero     (Zero),
        .Overflow (Overflow),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic lit(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: {overflow, result} of a single-cycle opcode
    function automatic logic [N:0] model_calc(input logic [3:0] op,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic signed [N:0] w;
        logic [N-1:0] r;
        logic o;
        int unsigned sh;
        r  = '0;
        o  = 1'b0;
        sh = int'(b[SW-1:0]);
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                w = $signed({a[N-1], a}) + $signed({b[N-1], b});
                r = w[N-1:0];
                o = (w[N] != w[N-1]);
            end
            4'b0011: r = a << sh;
            4'b0100: r = a >> sh;
            4'b0110: begin
                w = $signed({a[N-1], a}) - $signed({b[N-1], b});
                r = w[N-1:0];
                o = (w[N] != w[N-1]);
            end
            4'b0111: r = b;
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    // Model state
    logic [N-1:0] m_busw = '0;
    logic         m_zero = 1'b1;
    logic         m_ovf  = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [N-1:0] mul_res = '0;
    int           mul_left = 0;

    always @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            m_busw   <= '0;
            m_zero   <= 1'b1;
            m_ovf    <= 1'b0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            mul_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (mul_left != 0) begin
                mul_left <= mul_left - 1;
                if (mul_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_busw <= mul_res;
                    m_zero <= (mul_res == '0);
                    m_ovf  <= 1'b0;
                end
            end else if (Start) begin
                if (ALUCtrl == 4'b1000) begin
                    mul_res  <= BusA * BusB;
                    mul_left <= N;
                    m_busy   <= 1'b1;
                end else begin
                    logic [N:0] c;
                    c = model_calc(ALUCtrl, BusA, BusB);
                    m_busw <= c[N-1:0];
                    m_zero <= (c[N-1:0] == '0);
                    m_ovf  <= c[N];
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model
    always begin
        @(posedge CLK);
        #2;
        lit("cyc_busw", BusW, m_busw);
        lit("cyc_zero", N'(Zero), N'(m_zero));
        lit("cyc_ovf",  N'(Overflow), N'(m_ovf));
        lit("cyc_busy", N'(Busy), N'(m_busy));
        lit("cyc_done", N'(Done), N'(m_done));
    end

    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge CLK);
        Start   = 1'b1;
        ALUCtrl = op;
        BusA    = a;
        BusB    = b;
        @(negedge CLK);
        Start   = 1'b0;
    endtask

    task automatic wait_done(input string name, output int edges);
        edges = 1;
        while (!Done && edges < 200) begin
            @(negedge CLK);
            edges++;
        end
        lit(name, N'(Done), N'(1));
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         ovf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int bc;

        tbl[0] = '{4'b0000, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_FF00, 64'h00F0_0000_00FF_1200, 1'b0};
        tbl[1] = '{4'b0001, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0};
        tbl[2] = '{4'b0100, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0104, 64'h0800_0000_0000_0000, 1'b0};
        tbl[3] = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b1};
        tbl[4] = '{4'b0011, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0041, 64'h0000_0000_0000_0006, 1'b0};
        tbl[5] = '{4'b0101, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0000, 1'b0};
        tbl[6] = '{4'b0111, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_DEAD, 64'h0000_0000_0000_DEAD, 1'b0};
        tbl[7] = '{4'b0110, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0005, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};

        // Reset state
        repeat (3) @(negedge CLK);
        lit("rst_busw", BusW, '0);
        lit("rst_zero", N'(Zero), N'(1));
        lit("rst_ovf",  N'(Overflow), N'(0));
        lit("rst_busy", N'(Busy), N'(0));
        lit("rst_done", N'(Done), N'(0));
        resetl = 1'b1;

        // ADD 5+7
        issue(4'b0010, 64'd5, 64'd7);
        lit("add_done", N'(Done), N'(1));
        lit("add_busw", BusW, 64'd12);
        lit("add_zero", N'(Zero), N'(0));
        lit("add_ovf",  N'(Overflow), N'(0));
        lit("model_add", m_busw, 64'd12);

        // SUB with signed overflow, then SUB to zero
        issue(4'b0110, 64'h8000_0000_0000_0000, 64'd1);
        lit("sub_ovf_busw", BusW, 64'h7FFF_FFFF_FFFF_FFFF);
        lit("sub_ovf_ovf",  N'(Overflow), N'(1));
        lit("model_sub_ovf", N'(m_ovf), N'(1));
        issue(4'b0110, 64'd9, 64'd9);
        lit("sub_zero_busw", BusW, '0);
        lit("sub_zero_zero", N'(Zero), N'(1));
        lit("sub_zero_ovf",  N'(Overflow), N'(0));

        // MUL 3*5 with an ignored ADD Start and bus churn during EXEC
        issue(4'b1000, 64'd3, 64'd5);
        e  = 1;
        bc = 0;
        while (!Done && e < 200) begin
            if (Busy) bc++;
            Start   = (e == 20);
            ALUCtrl = (e >= 20) ? 4'b0010 : 4'b1000;
            BusA    = 64'(e) * 64'h1111;
            BusB    = 64'(e) + 64'd100;
            @(negedge CLK);
            e++;
        end
        Start = 1'b0;
        lit("mul_done",   N'(Done), N'(1));
        lit("mul_edge",   N'(e), N'(65));
        lit("mul_busy_n", N'(bc), N'(64));
        lit("mul_busw",   BusW, 64'd15);
        lit("model_mul",  m_busw, 64'd15);
        @(negedge CLK);
        lit("mul_done_once", N'(Done), N'(0));
        lit("mul_hold",      BusW, 64'd15);

        // MUL truncation, then LSL to the top bit
        issue(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_done("mul2_done", e);
        lit("mul2_busw", BusW, 64'hFFFF_FFFF_FFFF_FFFE);
        lit("mul2_ovf",  N'(Overflow), N'(0));
        issue(4'b0011, 64'd1, 64'd63);
        lit("lsl_busw", BusW, 64'h8000_0000_0000_0000);
        lit("lsl_zero", N'(Zero), N'(0));

        // Reset at EXEC cycle 10, then PassB on the first edge after release
        issue(4'b1000, 64'd3, 64'd5);
        repeat (9) @(negedge CLK);
        lit("pre_rst_busy", N'(Busy), N'(1));
        resetl = 1'b0;
        #1;
        lit("abort_busy", N'(Busy), N'(0));
        lit("abort_done", N'(Done), N'(0));
        lit("abort_busw", BusW, '0);
        lit("abort_zero", N'(Zero), N'(1));
        @(negedge CLK);
        lit("abort_nodone", N'(Done), N'(0));
        resetl  = 1'b1;
        Start   = 1'b1;
        ALUCtrl = 4'b0111;
        BusA    = 64'h5555;
        BusB    = 64'hA5;
        @(negedge CLK);
        Start = 1'b0;
        lit("passb_done",  N'(Done), N'(1));
        lit("passb_busw",  BusW, 64'hA5);
        lit("model_passb", m_busw, 64'hA5);

        // Undefined opcode
        issue(4'b1111, 64'h1234, 64'h5678);
        lit("undef_done", N'(Done), N'(1));
        lit("undef_busw", BusW, '0);
        lit("undef_zero", N'(Zero), N'(1));
        lit("undef_ovf",  N'(Overflow), N'(0));

        // Back-to-back single-cycle operations, one result per cycle
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                lit("b2b_busw", BusW, tbl[i-1].res);
                lit("b2b_ovf",  N'(Overflow), N'(tbl[i-1].ovf));
                lit("b2b_done", N'(Done), N'(1));
            end
            Start   = 1'b1;
            ALUCtrl = tbl[i].op;
            BusA    = tbl[i].a;
            BusB    = tbl[i].b;
        end
        @(negedge CLK);
        Start = 1'b0;
        lit("b2b_busw", BusW, tbl[7].res);
        lit("b2b_ovf",  N'(Overflow), N'(tbl[7].ovf));
        lit("b2b_done", N'(Done), N'(1));
        @(negedge CLK);
        lit("b2b_idle_done", N'(Done), N'(0));
        lit("b2b_hold",      BusW, tbl[7].res);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
